// File: rtl/regbank_wr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regbank_ctrl_pkg
// Shared types and constants for the register-bank write-port controller.
//   state_t       : controller states (IDLE / CLEAR)
//   DW_DEF etc.   : default data width, address width, register count
//   GNT_REQ0/1    : grant index encoding (0 = requester 0, 1 = requester 1)
//   grant_onehot  : turns a grant index into a one-hot grant vector
// -----------------------------------------------------------------------------
package regbank_ctrl_pkg;

   localparam int unsigned DW_DEF   = 32;
   localparam int unsigned AW_DEF   = 5;
   localparam int unsigned NREG_DEF = 32;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic GNT_REQ0 = 1'b0;
   localparam logic GNT_REQ1 = 1'b1;

   function automatic logic [1:0] grant_onehot(input logic idx);
      logic [1:0] v;
      if (idx == GNT_REQ1) begin
         v = 2'b10;
      end else begin
         v = 2'b01;
      end
      return v;
   endfunction

endpackage

// File: rtl/regbank_wr_ctrl_if.sv
// -----------------------------------------------------------------------------
// regbank_wr_ctrl_if
// Bundles the requester handshakes, the clear request/status and the bank
// write port driven by the controller.
//   master : requester/host side (drives valid/dr/data/clr_req)
//   slave  : controller side (drives ready, busy and the bank write port)
// -----------------------------------------------------------------------------
interface regbank_wr_ctrl_if
   import regbank_ctrl_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned AW = AW_DEF
);

   logic          clr_req;
   logic          busy;

   logic          req0_valid;
   logic [AW-1:0] req0_dr;
   logic [DW-1:0] req0_data;
   logic          req0_ready;

   logic          req1_valid;
   logic [AW-1:0] req1_dr;
   logic [DW-1:0] req1_data;
   logic          req1_ready;

   logic          write;
   logic [AW-1:0] dr;
   logic [DW-1:0] wrData;

   modport master (
      output clr_req,
      output req0_valid, req0_dr, req0_data,
      output req1_valid, req1_dr, req1_data,
      input  busy, req0_ready, req1_ready,
      input  write, dr, wrData
   );

   modport slave (
      input  clr_req,
      input  req0_valid, req0_dr, req0_data,
      input  req1_valid, req1_dr, req1_data,
      output busy, req0_ready, req1_ready,
      output write, dr, wrData
   );

endinterface

// File: rtl/regbank_wr_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. Holds the index of the last requester that
// completed a transfer; on contention the other requester wins.
//   clk, reset_n : clock, asynchronous active-low reset
//   req[1:0]     : request vector (bit N = requester N valid)
//   enable       : arbitration allowed this cycle (otherwise no grant)
//   accept       : a granted transfer completed at this edge
//   gnt[1:0]     : one-hot grant, or zero
// -----------------------------------------------------------------------------
module rr_arb2
   import regbank_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       enable,
   input  logic       accept,
   output logic [1:0] gnt
);

   logic       r_last_grant;
   logic [1:0] w_gnt;

   // Grant decode: single requester wins outright, contention goes to the
   // requester that did not win last time.
   always_comb begin
      w_gnt = 2'b00;
      if (enable) begin
         case (req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = (r_last_grant == GNT_REQ1) ? grant_onehot(GNT_REQ0)
                                                        : grant_onehot(GNT_REQ1);
            default: w_gnt = 2'b00;
         endcase
      end else begin
         w_gnt = 2'b00;
      end
   end

   assign gnt = w_gnt;

   // Last-grant flop; reset to requester 1 so requester 0 wins the first conflict.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= GNT_REQ1;
      end else if (accept) begin
         r_last_grant <= w_gnt[1];
      end else begin
         r_last_grant <= r_last_grant;
      end
   end

endmodule

// File: rtl/regbank_wr_ctrl.sv
// -----------------------------------------------------------------------------
// regbank_wr_ctrl
// Write-port controller in front of the register bank. Arbitrates two
// valid/ready requesters round-robin onto the single bank write port and runs
// a sequenced clear that writes zero to every register, one per cycle.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : slave modport of regbank_wr_ctrl_if
//             (clr_req/busy, req0_*/req1_* handshakes, write/dr/wrData)
// The bank write port (write/dr/wrData) and busy are registered; ready is
// combinational.
// -----------------------------------------------------------------------------
module regbank_wr_ctrl
   import regbank_ctrl_pkg::*;
#(
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned AW   = AW_DEF,
   parameter int unsigned NREG = NREG_DEF
)(
   input  logic             clk,
   input  logic             reset_n,
   regbank_wr_ctrl_if.slave bus
);

   localparam logic [AW-1:0] LP_CNT_LAST = AW'(NREG - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_cnt;
   logic [AW-1:0] w_cnt_nxt;

   logic          r_write;
   logic [AW-1:0] r_dr;
   logic [DW-1:0] r_wr_data;
   logic          r_busy;
   logic          w_write_nxt;
   logic [AW-1:0] w_dr_nxt;
   logic [DW-1:0] w_wr_data_nxt;
   logic          w_busy_nxt;

   logic [1:0]    w_req;
   logic [1:0]    w_gnt;
   logic          w_arb_en;
   logic          w_xfer;

   assign w_req    = {bus.req1_valid, bus.req0_valid};
   // A clear request in IDLE suppresses grants in the same cycle.
   assign w_arb_en = (r_state == IDLE) && !bus.clr_req;
   assign w_xfer   = |w_gnt;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (w_req),
      .enable  (w_arb_en),
      .accept  (w_xfer),
      .gnt     (w_gnt)
   );

   assign bus.req0_ready = w_gnt[0];
   assign bus.req1_ready = w_gnt[1];

   // Next-state, clear counter and next bank-port values.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_write_nxt   = 1'b0;
      w_dr_nxt      = r_dr;
      w_wr_data_nxt = r_wr_data;
      case (r_state)
         IDLE: begin
            if (bus.clr_req) begin
               w_state_nxt = CLEAR;
               w_cnt_nxt   = {AW{1'b0}};
            end else if (w_gnt[1]) begin
               w_write_nxt   = 1'b1;
               w_dr_nxt      = bus.req1_dr;
               w_wr_data_nxt = bus.req1_data;
            end else if (w_gnt[0]) begin
               w_write_nxt   = 1'b1;
               w_dr_nxt      = bus.req0_dr;
               w_wr_data_nxt = bus.req0_data;
            end else begin
               // Idle cycle: drop write, keep address/data for observability.
               w_write_nxt = 1'b0;
            end
         end
         CLEAR: begin
            w_write_nxt   = 1'b1;
            w_dr_nxt      = r_cnt;
            w_wr_data_nxt = {DW{1'b0}};
            if (r_cnt == LP_CNT_LAST) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = {AW{1'b0}};
            end else begin
               w_cnt_nxt = r_cnt + AW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = {AW{1'b0}};
            w_write_nxt = 1'b0;
         end
      endcase
      w_busy_nxt = (w_state_nxt == CLEAR);
   end

   // State and clear counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= {AW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Registered bank write port and busy flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_write   <= 1'b0;
         r_dr      <= {AW{1'b0}};
         r_wr_data <= {DW{1'b0}};
         r_busy    <= 1'b0;
      end else begin
         r_write   <= w_write_nxt;
         r_dr      <= w_dr_nxt;
         r_wr_data <= w_wr_data_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   assign bus.write  = r_write;
   assign bus.dr     = r_dr;
   assign bus.wrData = r_wr_data;
   assign bus.busy   = r_busy;

endmodule

// File: tb/tb_regbank_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regbank_wr_ctrl
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a transaction-level model of the controller, with a simple
// behavioural register bank attached to the write port.
// -----------------------------------------------------------------------------
module tb_regbank_wr_ctrl;

   logic clk;
   logic reset_n;

   regbank_wr_ctrl_if #(.DW(32), .AW(5)) bus ();

   regbank_wr_ctrl #(.DW(32), .AW(5), .NREG(32)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   // requester-side pending transactions
   bit          pend0, pend1;
   logic [4:0]  pa0, pa1;
   logic [31:0] pd0, pd1;

   // reference model state
   int          m_last;   // index of last accepted requester
   int          m_clr;    // next register to clear, -1 when not clearing
   logic        exp_write;
   logic [4:0]  exp_dr;
   logic [31:0] exp_data;
   logic        exp_busy;

   logic [31:0] bank [32];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural register bank fed by the controller's write port
   always @(posedge clk) begin
      if (reset_n && bus.write) bank[bus.dr] <= bus.wrData;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      m_last    = 1;
      m_clr     = -1;
      exp_write = 1'b0;
      exp_dr    = 5'd0;
      exp_data  = 32'd0;
      exp_busy  = 1'b0;
   endtask

   task automatic drop_inputs();
      pend0 = 1'b0;
      pend1 = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.clr_req    = 1'b0;
   endtask

   // Async reset pulse with immediate output check; returns just after release.
   task automatic do_reset(input string tag);
      drop_inputs();
      #2;
      reset_n = 1'b0;
      #1;
      chk({tag, "_write"}, 32'(bus.write), 32'd0);
      chk({tag, "_dr"},    32'(bus.dr),    32'd0);
      chk({tag, "_data"},  bus.wrData,     32'd0);
      chk({tag, "_busy"},  32'(bus.busy),  32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   // One clock cycle: check outputs, drive requests, check ready, advance model.
   task automatic step(input bit w0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit w1, input logic [4:0] a1, input logic [31:0] d1,
                       input bit clr);
      bit xfer;
      int win;
      @(negedge clk);
      chk("write", 32'(bus.write), 32'(exp_write));
      chk("busy",  32'(bus.busy),  32'(exp_busy));
      if (exp_write) begin
         chk("dr",   32'(bus.dr), 32'(exp_dr));
         chk("data", bus.wrData,  exp_data);
      end
      if (!pend0 && w0) begin pend0 = 1'b1; pa0 = a0; pd0 = d0; end
      if (!pend1 && w1) begin pend1 = 1'b1; pa1 = a1; pd1 = d1; end
      bus.req0_valid = pend0; bus.req0_dr = pa0; bus.req0_data = pd0;
      bus.req1_valid = pend1; bus.req1_dr = pa1; bus.req1_data = pd1;
      bus.clr_req    = clr;
      #1;
      xfer = 1'b0;
      win  = 0;
      if (m_clr < 0 && !clr) begin
         if (pend0 && pend1) begin win = (m_last == 1) ? 0 : 1; xfer = 1'b1; end
         else if (pend0)     begin win = 0; xfer = 1'b1; end
         else if (pend1)     begin win = 1; xfer = 1'b1; end
      end
      chk("ready0", 32'(bus.req0_ready), 32'(xfer && win == 0));
      chk("ready1", 32'(bus.req1_ready), 32'(xfer && win == 1));
      if (m_clr >= 0) begin
         exp_write = 1'b1;
         exp_dr    = m_clr[4:0];
         exp_data  = 32'd0;
         m_clr     = (m_clr == 31) ? -1 : m_clr + 1;
      end else if (clr) begin
         exp_write = 1'b0;
         m_clr     = 0;
      end else if (xfer) begin
         exp_write = 1'b1;
         exp_dr    = (win == 1) ? pa1 : pa0;
         exp_data  = (win == 1) ? pd1 : pd0;
         m_last    = win;
         if (win == 1) pend1 = 1'b0; else pend0 = 1'b0;
      end else begin
         exp_write = 1'b0;
      end
      exp_busy = (m_clr >= 0);
      @(posedge clk);
   endtask

   task automatic idle_step();
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0;
      drop_inputs();
      bus.req0_dr = 5'd0; bus.req0_data = 32'd0;
      bus.req1_dr = 5'd0; bus.req1_data = 32'd0;
      pa0 = 5'd0; pd0 = 32'd0; pa1 = 5'd0; pd1 = 32'd0;
      model_reset();
      #3;
      chk("por_write", 32'(bus.write), 32'd0);
      chk("por_busy",  32'(bus.busy),  32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // contention from reset: grants alternate 0,1,0,1
      for (int i = 0; i < 4; i++) step(1'b1, 5'd1, 32'h1111_0000 + 32'(i), 1'b1, 5'd2, 32'h2222_0000 + 32'(i), 1'b0);
      for (int i = 0; i < 3; i++) idle_step();

      // single requester
      step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0);
      idle_step();
      idle_step();

      // clear issued together with a request from requester 1
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777_7777, 1'b1);
      for (int i = 0; i < 34; i++) idle_step();

      // reset in the middle of a clear, just after dr=10 was loaded
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
      for (int i = 0; i < 11; i++) idle_step();
      #1;
      chk("midclr_dr", 32'(bus.dr), 32'd10);
      do_reset("midclr");
      for (int i = 0; i < 4; i++) idle_step();

      // fill the bank, then clear it
      for (int i = 0; i < 32; i++) step(1'b1, 5'(i), 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0, 1'b0);
      idle_step();
      #1;
      for (int i = 0; i < 32; i++) chk($sformatf("fill%0d", i), bank[i], 32'hA5A5_A5A5);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
      for (int i = 0; i < 33; i++) idle_step();
      #1;
      for (int i = 0; i < 32; i++) chk($sformatf("clr%0d", i), bank[i], 32'd0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 1)), 5'($urandom), 32'($urandom),
              1'($urandom_range(0, 1)), 5'($urandom), 32'($urandom),
              ($urandom_range(0, 39) == 0));
      end
      for (int i = 0; i < 40; i++) idle_step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/regbank_wr_ctrl.md
# regbank_wr_ctrl

Write-port controller for the 32 x 32 register bank. It shares the bank's single write port between two requesters using round-robin arbitration with a valid/ready handshake. It also runs a sequenced clear that zeroes all 32 registers, one per cycle, on request. The block sits directly in front of the bank: its `write`/`dr`/`wrData` outputs drive the bank's write inputs.

## Interface
- `DW`, default 32: data width.
- `AW`, default 5: register address width.
- `NREG`, default 32: number of registers to clear; equals 2^AW.
- `clk`  in  1: clock; all state changes on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `clr_req`  in  1: request a full-bank clear; sampled only in IDLE.
- `busy`  out  1: high while in CLEAR.
- `req0_valid` / `req1_valid`  in  1: write request from requester 0 / 1.
- `req0_dr` / `req1_dr`  in  AW: destination register.
- `req0_data` / `req1_data`  in  DW: write data.
- `req0_ready` / `req1_ready`  out  1: request accepted this cycle. Combinational.
- `write`  out  1: bank write enable. Registered.
- `dr`  out  AW: bank destination register. Registered.
- `wrData`  out  DW: bank write data. Registered.

## Operation
- **States:** IDLE and CLEAR. Reset enters IDLE.
- **Reset values:** `write`=0, `dr`=0, `wrData`=0, `busy`=0, `last_grant`=1 (so req0 wins the first conflict), clear counter `cnt`=0.
- **Handshake:** a transfer occurs when `reqN_valid && reqN_ready`.
  - A requester holds `valid`, `dr` and `data` stable until it sees `ready`.
  - `ready` never depends on anything that the same requester's `valid` drives.
- **IDLE, clr_req=0:**
  - Only one requester valid: that requester gets `ready`=1.
  - Both valid: grant goes to the requester that is not `last_grant`.
  - `last_grant` updates on every transfer.
  - At most one `ready` is high per cycle.
- **IDLE, clr_req=1:** both `ready`=0 (clear wins over requests in the same cycle). Next state is CLEAR with `cnt`=0.
- **Output register on each edge:**
  - Transfer: `write`=1, and `dr`/`wrData` take the granted payload.
  - No transfer and not clearing: `write`=0, and `dr`/`wrData` hold their previous value.
- **CLEAR:**
  - Both `ready`=0 and `clr_req` is ignored.
  - Each edge loads `write`=1, `dr`=`cnt`, `wrData`=0, then increments `cnt`.
  - On the edge where `cnt`==NREG-1, the state returns to IDLE and `cnt` goes to 0.
- **Reset mid-clear:** aborts immediately. The bank is left partially cleared, and no further writes are issued.
- **Requester holding valid during CLEAR:** stalls and is accepted after return to IDLE under normal arbitration.

## Timing
- **Write latency:** 1 cycle. A transfer at edge E appears on `write`/`dr`/`wrData` during the cycle after E. The bank commits it at edge E+1.
- **Throughput:** one write per cycle in IDLE. Back-to-back transfers are allowed, alternating when both requesters stay valid.
- **Clear sequence:**
  - `clr_req` sampled at edge E0 sets `busy`=1 after E0.
  - Edges E1..E32 load `dr`=0..31 with `write`=1.
  - The state returns to IDLE at E32, so `busy` is high for exactly 32 cycles.
  - The final clear write (`dr`=31) is on the outputs during the cycle after E32, while `busy`=0.
- **First post-clear grant:** possible in the cycle after E32. Its write appears after E33, so there is no port conflict.

## Structure
- **Package `regbank_ctrl_pkg`:**
  - `state_t` enum with IDLE and CLEAR.
  - Default `DW`/`AW`/`NREG` constants.
  - Grant encoding: 0 = req0, 1 = req1.
- **Sub-module `rr_arb2`:**
  - Two-input round-robin arbiter holding the `last_grant` flop.
  - Inputs: `req[1:0]`, `enable`, `accept`.
  - Output: `gnt[1:0]`, one-hot or zero.
- **Top level:** FSM, clear counter, and output register.

## Test plan
- **Reset:** assert `reset_n`=0 mid-cycle → all outputs 0 asynchronously; `busy`=0.
- **Single requester:** req0 only, `dr`=5, data=0xDEADBEEF → `req0_ready`=1 the same cycle; next cycle `write`=1, `dr`=5, `wrData`=0xDEADBEEF.
- **Contention:** both valid for 4 cycles (req0 `dr`=1, req1 `dr`=2) → grants 0,1,0,1; `write` outputs `dr`=1,2,1,2 on consecutive cycles.
- **Clear with pending request:** `clr_req` and req1 both high in the same cycle → `req1_ready`=0; `busy` is high for 32 cycles; writes `dr`=0..31 with data 0; req1 is accepted in the cycle after `busy` falls.
- **Reset during clear:** pulse `reset_n` low after the write to `dr`=10 → state IDLE, `write`=0; no `dr`=11 write is issued.
- **Bank readback:** integrate with the register bank, write 0xA5A5A5A5 to all registers, then clear → every read port returns 0.
